// File: rtl/rr_lock_arbiter_pkg.sv
// Shared helpers for the transaction-locking round-robin arbiter.
// Index width and cyclic increment that also hold for non-power-of-two counts.
package rr_lock_arbiter_pkg;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int next_idx(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/rr_lock_arbiter_if.sv
// Requester-side and downstream-side channel bundle of the arbiter.
// The arbiter takes the slave view; the requesters/sink take the master view.
interface rr_lock_arbiter_if
    import rr_lock_arbiter_pkg::*;
#(
    parameter int NUM = 4,
    parameter int DIN = 16
) ();

    localparam int IW = idx_w(NUM);

    logic [NUM-1:0]     din_valid;
    logic [NUM-1:0]     din_ready;
    logic [NUM*DIN-1:0] din_data;
    logic [NUM-1:0]     din_eot;
    logic               dout_valid;
    logic               dout_ready;
    logic [DIN-1:0]     dout_data;
    logic               dout_eot;
    logic [IW-1:0]      dout_ctrl;

    modport slave (
        input  din_valid,
        input  din_data,
        input  din_eot,
        input  dout_ready,
        output din_ready,
        output dout_valid,
        output dout_data,
        output dout_eot,
        output dout_ctrl
    );

    modport master (
        output din_valid,
        output din_data,
        output din_eot,
        output dout_ready,
        input  din_ready,
        input  dout_valid,
        input  dout_data,
        input  dout_eot,
        input  dout_ctrl
    );

endinterface

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: first set request at or after ptr, cyclically.
// With no request set the index falls back to ptr itself.
module rr_prio_enc
    import rr_lock_arbiter_pkg::*;
#(
    parameter int NUM = 4,
    parameter int IW  = idx_w(NUM)
) (
    input  logic [NUM-1:0] req_i,
    input  logic [IW-1:0]  ptr_i,
    output logic [IW-1:0]  gnt_idx_o,
    output logic           gnt_any_o
);

    logic [NUM-1:0] rot;
    int             k;
    int             s;

    always_comb begin
        rot = NUM'({req_i, req_i} >> ptr_i);
        k   = 0;
        for (int j = NUM - 1; j >= 0; j--) begin
            if (rot[j]) k = j;
        end
        s = int'(ptr_i) + k;
        if (s >= NUM) s = s - NUM;
        gnt_idx_o = IW'(s);
    end

    assign gnt_any_o = |req_i;

endmodule

// File: rtl/rr_lock_arbiter.sv
// N-way round-robin arbiter that locks the shared channel per transaction.
// Forward path is combinational; only the lock and priority pointer are stored.
module rr_lock_arbiter
    import rr_lock_arbiter_pkg::*;
#(
    parameter int NUM = 4,
    parameter int DIN = 16
) (
    input  logic               clk,
    input  logic               rst,
    rr_lock_arbiter_if.slave   bus
);

    localparam int IW = idx_w(NUM);

    logic          locked_q;
    logic          locked_d;
    logic [IW-1:0] lock_idx_q;
    logic [IW-1:0] lock_idx_d;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    logic [IW-1:0] enc_idx;
    logic          enc_any;
    logic [IW-1:0] sel;
    logic          vld_sel;
    logic          hs;

    rr_prio_enc #(
        .NUM (NUM),
        .IW  (IW)
    ) u_enc (
        .req_i     (bus.din_valid),
        .ptr_i     (ptr_q),
        .gnt_idx_o (enc_idx),
        .gnt_any_o (enc_any)
    );

    assign sel     = locked_q ? lock_idx_q : enc_idx;
    assign vld_sel = locked_q ? bus.din_valid[lock_idx_q] : enc_any;

    // Outputs are held low while in reset so no beat can transfer.
    assign bus.dout_valid = ~rst & vld_sel;
    assign bus.dout_data  = rst ? '0 : bus.din_data[sel*DIN +: DIN];
    assign bus.dout_eot   = ~rst & bus.din_eot[sel];
    assign bus.dout_ctrl  = rst ? '0 : sel;

    assign hs            = bus.dout_valid & bus.dout_ready;
    assign bus.din_ready = hs ? (NUM'(1) << sel) : '0;

    always_comb begin
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        ptr_d      = ptr_q;
        if (bus.dout_valid) begin
            if (hs && bus.dout_eot) begin
                locked_d = 1'b0;
                ptr_d    = IW'(next_idx(int'(sel), NUM));
            end else begin
                locked_d   = 1'b1;
                lock_idx_d = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
            ptr_q      <= '0;
        end else begin
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
            ptr_q      <= ptr_d;
        end
    end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter: a NUM=4 and a NUM=3 instance.
// The pointer is observed as dout_ctrl on idle cycles.
module tb_rr_lock_arbiter;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    rr_lock_arbiter_if #(.NUM(4), .DIN(16)) a4 ();
    rr_lock_arbiter_if #(.NUM(3), .DIN(16)) a3 ();

    rr_lock_arbiter #(.NUM(4), .DIN(16)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (a4)
    );

    rr_lock_arbiter #(.NUM(3), .DIN(16)) u3 (
        .clk (clk),
        .rst (rst),
        .bus (a3)
    );

    logic [15:0] d4 [4];
    logic [15:0] d3 [3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc4(input logic r, input logic [3:0] v, input logic [3:0] e,
                        input logic rdy);
        @(negedge clk);
        rst           = r;
        a4.din_valid  = v;
        a4.din_eot    = e;
        a4.dout_ready = rdy;
        #1;
    endtask

    task automatic cyc3(input logic [2:0] v, input logic [2:0] e, input logic rdy);
        @(negedge clk);
        a3.din_valid  = v;
        a3.din_eot    = e;
        a3.dout_ready = rdy;
        #1;
    endtask

    task automatic exp4(input string tag, input logic vld, input logic [1:0] ctrl,
                        input logic [3:0] rdy);
        chk({tag, ".vld"}, 32'(a4.dout_valid), 32'(vld));
        chk({tag, ".ctrl"}, 32'(a4.dout_ctrl), 32'(ctrl));
        chk({tag, ".rdy"}, 32'(a4.din_ready), 32'(rdy));
        chk({tag, ".oh"}, 32'($onehot0(a4.din_ready)), 32'd1);
        if (vld) begin
            chk({tag, ".data"}, 32'(a4.dout_data), 32'(d4[ctrl]));
            chk({tag, ".eot"}, 32'(a4.dout_eot), 32'(a4.din_eot[ctrl]));
        end
    endtask

    task automatic exp3(input string tag, input logic vld, input logic [1:0] ctrl,
                        input logic [2:0] rdy);
        chk({tag, ".vld"}, 32'(a3.dout_valid), 32'(vld));
        chk({tag, ".ctrl"}, 32'(a3.dout_ctrl), 32'(ctrl));
        chk({tag, ".rdy"}, 32'(a3.din_ready), 32'(rdy));
        if (vld) chk({tag, ".data"}, 32'(a3.dout_data), 32'(d3[ctrl]));
    endtask

    task automatic exp_rst(input string tag);
        chk({tag, ".vld"}, 32'(a4.dout_valid), 32'd0);
        chk({tag, ".rdy"}, 32'(a4.din_ready), 32'd0);
        chk({tag, ".ctrl"}, 32'(a4.dout_ctrl), 32'd0);
        chk({tag, ".data"}, 32'(a4.dout_data), 32'd0);
        chk({tag, ".eot"}, 32'(a4.dout_eot), 32'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        d4 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        d3 = '{16'h0AA0, 16'h0AA1, 16'h0AA2};
        rst           = 1'b1;
        a4.din_valid  = '0;
        a4.din_eot    = '0;
        a4.dout_ready = 1'b0;
        a4.din_data   = {d4[3], d4[2], d4[1], d4[0]};
        a3.din_valid  = '0;
        a3.din_eot    = '0;
        a3.dout_ready = 1'b0;
        a3.din_data   = {d3[2], d3[1], d3[0]};

        // reset with every input requesting
        cyc4(1, 4'b1111, 4'b1111, 1); exp_rst("rst0");
        chk("rst0.u3vld", 32'(a3.dout_valid), 32'd0);

        // single requester, 3-beat transaction
        cyc4(0, 4'b0100, 4'b0000, 1); exp4("t1b1", 1, 2, 4'b0100);
        cyc4(0, 4'b0100, 4'b0000, 1); exp4("t1b2", 1, 2, 4'b0100);
        cyc4(0, 4'b0100, 4'b0100, 1); exp4("t1b3", 1, 2, 4'b0100);
        cyc4(0, 4'b0000, 4'b0000, 1); exp4("t1ptr", 0, 3, 4'b0000);

        // bring ptr back to 0, then all valid single beats
        cyc4(0, 4'b1000, 4'b1000, 1); exp4("t2pre", 1, 3, 4'b1000);
        cyc4(0, 4'b1111, 4'b1111, 1); exp4("t2g0", 1, 0, 4'b0001);
        cyc4(0, 4'b1111, 4'b1111, 1); exp4("t2g1", 1, 1, 4'b0010);
        cyc4(0, 4'b1111, 4'b1111, 1); exp4("t2g2", 1, 2, 4'b0100);
        cyc4(0, 4'b1111, 4'b1111, 1); exp4("t2g3", 1, 3, 4'b1000);
        cyc4(0, 4'b1111, 4'b1111, 1); exp4("t2g4", 1, 0, 4'b0001);

        // backpressure: req1 presented, req0 joins, ptr=1
        cyc4(0, 4'b0010, 4'b0010, 0); exp4("t3c0", 1, 1, 4'b0000);
        cyc4(0, 4'b0010, 4'b0010, 0); exp4("t3c1", 1, 1, 4'b0000);
        cyc4(0, 4'b0011, 4'b0011, 0); exp4("t3c2", 1, 1, 4'b0000);
        cyc4(0, 4'b0011, 4'b0011, 0); exp4("t3c3", 1, 1, 4'b0000);
        cyc4(0, 4'b0011, 4'b0011, 0); exp4("t3c4", 1, 1, 4'b0000);
        cyc4(0, 4'b0011, 4'b0011, 1); exp4("t3hs", 1, 1, 4'b0010);
        cyc4(0, 4'b1001, 4'b1001, 1); exp4("t3r3", 1, 3, 4'b1000);
        cyc4(0, 4'b0001, 4'b0001, 1); exp4("t3r0", 1, 0, 4'b0001);

        // locked req3 idles mid-transaction while req0 waits
        cyc4(0, 4'b1000, 4'b0000, 1); exp4("t4b1", 1, 3, 4'b1000);
        cyc4(0, 4'b0001, 4'b0001, 1); exp4("t4gap0", 0, 3, 4'b0000);
        cyc4(0, 4'b0001, 4'b0001, 1); exp4("t4gap1", 0, 3, 4'b0000);
        cyc4(0, 4'b1001, 4'b1001, 1); exp4("t4eot", 1, 3, 4'b1000);
        cyc4(0, 4'b0000, 4'b0000, 1); exp4("t4ptr", 0, 0, 4'b0000);
        cyc4(0, 4'b0001, 4'b0001, 1); exp4("t4r0", 1, 0, 4'b0001);

        // reset while req2 holds the lock
        cyc4(0, 4'b0100, 4'b0000, 1); exp4("t5b1", 1, 2, 4'b0100);
        cyc4(1, 4'b0110, 4'b0110, 1); exp_rst("t5rst");
        cyc4(0, 4'b0110, 4'b0110, 1); exp4("t5g", 1, 1, 4'b0010);
        cyc4(0, 4'b0000, 4'b0000, 1); exp4("t5ptr", 0, 2, 4'b0000);

        // NUM=3 wrap
        cyc3(3'b111, 3'b111, 1); exp3("n3g0", 1, 0, 3'b001);
        cyc3(3'b111, 3'b111, 1); exp3("n3g1", 1, 1, 3'b010);
        cyc3(3'b111, 3'b111, 1); exp3("n3g2", 1, 2, 3'b100);
        cyc3(3'b111, 3'b111, 1); exp3("n3g3", 1, 0, 3'b001);
        cyc3(3'b000, 3'b000, 1); exp3("n3ptr", 0, 1, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
